// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode encodings for the LED pattern generator
package led_pkg;

  typedef enum logic [2:0] {
    MODE_ROT_DOWN = 3'd0,
    MODE_ROT_UP   = 3'd1,
    MODE_FILL     = 3'd2,
    MODE_DRAIN    = 3'd3,
    MODE_BOUNCE   = 3'd4,
    MODE_BLINK    = 3'd5,
    MODE_RSVD6    = 3'd6,
    MODE_RSVD7    = 3'd7
  } led_mode_e;

  localparam int MODE_W = 3;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - pattern-step tick counter with one-cycle tick pulse
module led_tick_gen #(
  parameter int TICK_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST      = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(TICK_CYCLES - 2);

  logic [CW-1:0] cnt;

  // Count 0..TICK_CYCLES-1; tick_o is registered one count early so it is high exactly while cnt == LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
      tick_o <= (cnt == PRE_LAST);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern sequencer with PWM brightness control
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int LED_NUM     = 4,
  parameter int TICK_CYCLES = 20_000_000,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MODE_W-1:0]   mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [LED_NUM-1:0]  led,
  output logic                tick_o
);

  localparam logic [LED_NUM-1:0] ONE_LSB  = {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [LED_NUM-1:0] ONE_MSB  = {1'b1, {(LED_NUM-1){1'b0}}};
  localparam logic [LED_NUM-1:0] ALL_ONES = {LED_NUM{1'b1}};

  led_mode_e            mode_in;
  led_mode_e            mode_q;
  logic [LED_NUM-1:0]   pattern;
  logic                 dir_up;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic                 pwm_on;
  logic [LED_NUM-1:0]   init_pat;
  logic [LED_NUM-1:0]   step_pat;
  logic                 step_dir;

  assign mode_in = led_mode_e'(mode);
  assign pwm_on  = (pwm_cnt < brightness);

  led_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick_o(tick_o)
  );

  // Starting pattern for the mode currently on the input pins
  always_comb begin
    init_pat = '0;
    case (mode_in)
      MODE_ROT_DOWN: init_pat = ONE_MSB;
      MODE_ROT_UP:   init_pat = ONE_LSB;
      MODE_FILL:     init_pat = '0;
      MODE_DRAIN:    init_pat = ALL_ONES;
      MODE_BOUNCE:   init_pat = ONE_LSB;
      MODE_BLINK:    init_pat = ALL_ONES;
      default:       init_pat = '0;
    endcase
  end

  // One step of the active mode; bounce flips direction as the lit bit lands on an end
  always_comb begin
    step_pat = pattern;
    step_dir = dir_up;
    case (mode_q)
      MODE_ROT_DOWN: step_pat = {pattern[0], pattern[LED_NUM-1:1]};
      MODE_ROT_UP:   step_pat = {pattern[LED_NUM-2:0], pattern[LED_NUM-1]};
      MODE_FILL:     step_pat = (pattern == ALL_ONES) ? '0 : {pattern[LED_NUM-2:0], 1'b1};
      MODE_DRAIN:    step_pat = (pattern == '0) ? ALL_ONES : {1'b0, pattern[LED_NUM-1:1]};
      MODE_BOUNCE: begin
        if (dir_up) begin
          step_pat = pattern << 1;
          if (pattern[LED_NUM-2]) step_dir = 1'b0;
        end else begin
          step_pat = pattern >> 1;
          if (pattern[1]) step_dir = 1'b1;
        end
      end
      MODE_BLINK:    step_pat = ~pattern;
      default:       step_pat = '0;
    endcase
  end

  // Pattern state machine, free-running PWM counter and registered LED drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_ROT_DOWN;
      pattern <= ONE_MSB;
      dir_up  <= 1'b1;
      pwm_cnt <= '0;
      led     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led     <= pattern & {LED_NUM{pwm_on}};
      if (tick_o) begin
        if (mode_in != mode_q) begin
          mode_q  <= mode_in;
          pattern <= init_pat;
          dir_up  <= 1'b1;
        end else begin
          pattern <= step_pat;
          dir_up  <= step_dir;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen
module tb_led_pattern_gen;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] brightness = 8'd255;
  logic [3:0] led;
  logic       tick_o;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [2:0]      mode;
    int              n;
    logic [0:8][3:0] exp;
  } vec_t;

  vec_t vecs[7];

  led_pattern_gen #(
    .LED_NUM(4), .TICK_CYCLES(4), .PWM_BITS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .brightness(brightness),
    .led(led), .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: at each tick cycle led shows the pattern set up by the previous tick
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n && tick_o && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led !== e) begin
        errors++;
        $display("FAIL tick_led got %b want %b", led, e);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push(input logic [3:0] v);
    exp_q.push_back(v);
  endtask

  task automatic count_lit(input int cycles, output int lit);
    lit = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (led != 4'b0) lit++;
    end
  endtask

  initial begin
    int lit;
    int cnt;
    vecs[0] = '{MODE_ROT_DOWN, 5, {4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0}};
    vecs[1] = '{MODE_ROT_UP,   6, {4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0, 4'b0, 4'b0}};
    vecs[2] = '{MODE_FILL,     7, {4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0, 4'b0}};
    vecs[3] = '{MODE_DRAIN,    7, {4'b1000, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1111, 4'b0, 4'b0}};
    vecs[4] = '{MODE_BOUNCE,   9, {4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010}};
    vecs[5] = '{MODE_BLINK,    4, {4'b1000, 4'b1111, 4'b0000, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0}};
    vecs[6] = '{MODE_RSVD7,    3, {4'b1000, 4'b0000, 4'b0000, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0}};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_led", int'(led), 0);
    check("reset_tick", int'(tick_o), 0);

    // table of per-mode tick sequences, each from a fresh reset
    for (int i = 0; i < 7; i++) begin
      mode = vecs[i].mode;
      do_reset();
      for (int j = 0; j < vecs[i].n; j++) push(vecs[i].exp[j]);
      drain();
    end

    // mode glitch that reverts before the tick, then a real change to fill mid-interval
    mode = MODE_ROT_DOWN;
    do_reset();
    push(4'b1000); push(4'b0100);
    drain();
    @(posedge clk); @(negedge clk);
    mode = MODE_DRAIN;
    @(negedge clk);
    mode = MODE_ROT_DOWN;
    push(4'b0010); push(4'b0001);
    drain();
    @(posedge clk); @(negedge clk);
    mode = MODE_FILL;
    push(4'b1000); push(4'b0000); push(4'b0001); push(4'b0011);
    push(4'b0111); push(4'b1111); push(4'b0000);
    drain();

    // asynchronous reset pulse between edges during a tick cycle
    mode = MODE_ROT_DOWN;
    cnt = 0;
    while (!(tick_o && led != 4'b0) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("pulse_precond", int'(tick_o && led != 4'b0), 1);
    #1 rst_n = 1'b0;
    #1;
    check("pulse_led", int'(led), 0);
    check("pulse_tick", int'(tick_o), 0);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_tick_%0d", k), int'(tick_o), (k == 3) ? 1 : 0);
    end
    check("post_rst_led", int'(led), 4'b1000);

    // reserved mode: dark LEDs, tick keeps its period
    mode = MODE_RSVD6;
    do_reset();
    push(4'b1000); push(4'b0000); push(4'b0000);
    drain();
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      do begin
        @(posedge clk);
        #1;
        cnt++;
      end while (!tick_o && cnt < 20);
      if (k > 0) check("rsvd_tick_period", cnt, 4);
      check("rsvd_led", int'(led), 0);
    end

    // PWM duty
    mode = MODE_ROT_DOWN;
    brightness = 8'd64;
    do_reset();
    repeat (10) @(posedge clk);
    count_lit(256, lit);
    check("duty_64", lit, 64);
    brightness = 8'd255;
    repeat (2) @(posedge clk);
    count_lit(256, lit);
    check("duty_255", lit, 255);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (led == 4'b0 && cnt < 20);
    brightness = 8'd0;
    @(posedge clk);
    #1;
    check("bright_next_edge", int'(led), 0);
    count_lit(256, lit);
    check("duty_0", lit, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
